// File: rtl/pending_encoder32to5.sv
// Registered 32-to-5 priority encoder: request pulses accumulate in a pending
// register and one index at a time is offered to a consumer over valid/ack.
module pending_encoder32to5 #(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] req,
   input  logic        ack,
   output logic [4:0]  idx,
   output logic        valid,
   output logic [31:0] pending
);

   // The output register doubles as the FSM: valid is the state bit itself.
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESENT = 1'b1;

   logic [0:0]  state_q;
   logic [4:0]  idx_q;
   logic [31:0] pend_q;

   logic [31:0] clr;
   logic [31:0] p_next;
   logic [31:0] set_bits;

   function automatic logic [4:0] enc(input logic [31:0] v);
      logic [4:0] r;
      r = 5'd0;
      if (LOW_FIRST) begin
         for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (v[i]) r = 5'(i);
         end
      end
      return r;
   endfunction

   // Handshake: idx is offered while valid=1 and held until ack=1 is seen on
   // a rising edge; that edge retires the index and clears its pending bit.
   // ack is ignored while valid=0. New requests join the pending set only
   // after the edge they are sampled on, so set beats clear on one bit.
   always_comb begin
      clr      = '0;
      if ((state_q == ST_PRESENT) && ack) clr = 32'd1 << idx_q;
      p_next   = pend_q & ~clr;
      set_bits = en ? req : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= '0;
         state_q <= ST_IDLE;
         idx_q   <= 5'd0;
      end else begin
         pend_q <= p_next | set_bits;
         if ((state_q == ST_IDLE) || ack) begin
            state_q <= (|p_next) ? ST_PRESENT : ST_IDLE;
            idx_q   <= enc(p_next);
         end
      end
   end

   assign valid   = (state_q == ST_PRESENT);
   assign idx     = idx_q;
   assign pending = pend_q;

endmodule
